// File: rtl/q_requant_arbiter_if.sv
// Handshake bundle for the shared requantizer: N request lanes in, one tagged result out.
// The slave modport is the arbiter's view; the master modport is the requesters' and consumer's view.
interface q_requant_arbiter_if #(
    parameter int N_REQ = 4,
    parameter int IN_I  = 8,
    parameter int IN_F  = 16,
    parameter int OUT_F = 8
);
    localparam int W_IN  = IN_I + IN_F;
    localparam int W_OUT = IN_I + OUT_F;
    localparam int IDW   = (N_REQ > 1) ? $clog2(N_REQ) : 1;

    logic [N_REQ-1:0]      req_valid;
    logic [N_REQ-1:0]      req_ready;
    logic [N_REQ*W_IN-1:0] req_data;
    logic                  out_valid;
    logic                  out_ready;
    logic [W_OUT-1:0]      out_data;
    logic [IDW-1:0]        out_id;
    logic                  out_sat;

    modport slave (
        input  req_valid, req_data, out_ready,
        output req_ready, out_valid, out_data, out_id, out_sat
    );

    modport master (
        output req_valid, req_data, out_ready,
        input  req_ready, out_valid, out_data, out_id, out_sat
    );
endinterface

// File: rtl/q_requant_arbiter.sv
// Round-robin arbiter sharing one round-half-up, saturating Q(IN_I,IN_F)->Q(IN_I,OUT_F) requantizer.
// Two-stage pipeline (S1 = operand, S2 = result), results tagged with requester id, saturation counter.
module q_requant_arbiter #(
    parameter int N_REQ = 4,
    parameter int IN_I  = 8,
    parameter int IN_F  = 16,
    parameter int OUT_F = 8
) (
    input  logic                    clock,
    input  logic                    reset_n,
    q_requant_arbiter_if.slave      rq,
    input  logic                    sat_clear,
    output logic [15:0]             sat_count
);
    localparam int W_IN  = IN_I + IN_F;
    localparam int W_OUT = IN_I + OUT_F;
    localparam int SH    = IN_F - OUT_F;
    localparam int IDW   = (N_REQ > 1) ? $clog2(N_REQ) : 1;

    localparam logic signed [W_IN:0] BIAS    = (W_IN+1)'(1) << (SH - 1);
    localparam logic signed [W_IN:0] OUT_MAX = (W_IN+1)'((64'sd1 <<< (W_OUT - 1)) - 64'sd1);
    localparam logic signed [W_IN:0] OUT_MIN = ~OUT_MAX;

    logic                 v1_q, v1_d;
    logic [W_IN-1:0]      op1_q, op1_d;
    logic [IDW-1:0]       id1_q, id1_d;
    logic                 v2_q, v2_d;
    logic [W_OUT-1:0]     res2_q, res2_d;
    logic [IDW-1:0]       id2_q, id2_d;
    logic                 sat2_q, sat2_d;
    logic [IDW-1:0]       ptr_q, ptr_d;
    logic [15:0]          sat_cnt_q, sat_cnt_d;

    logic                 adv1, adv2;
    logic                 grant_found;
    logic [IDW-1:0]       grant_idx;
    logic [N_REQ-1:0]     grant_oh;
    logic                 transfer;
    logic signed [W_IN:0] ext_op, biased, shifted;
    logic [W_OUT-1:0]     res_calc;
    logic                 sat_calc;

    assign adv2 = !v2_q || rq.out_ready;
    assign adv1 = !v1_q || adv2;

    // First valid requester at or after ptr, wrapping; ready is withheld in reset and when S1 cannot move.
    always_comb begin
        int idx;
        grant_found = 1'b0;
        grant_idx   = '0;
        grant_oh    = '0;
        for (int k = 0; k < N_REQ; k++) begin
            idx = (int'(ptr_q) + k) % N_REQ;
            if (!grant_found && rq.req_valid[idx]) begin
                grant_found = 1'b1;
                grant_idx   = IDW'(idx);
            end
        end
        if (grant_found) begin
            grant_oh[grant_idx] = 1'b1;
        end
    end

    assign rq.req_ready = (adv1 && reset_n) ? grant_oh : '0;
    assign transfer     = grant_found && adv1 && reset_n;

    // One spare top bit keeps the rounding bias add from wrapping before the clamp.
    always_comb begin
        ext_op   = {op1_q[W_IN-1], op1_q};
        biased   = ext_op + BIAS;
        shifted  = biased >>> SH;
        res_calc = shifted[W_OUT-1:0];
        sat_calc = 1'b0;
        if (shifted > OUT_MAX) begin
            res_calc = OUT_MAX[W_OUT-1:0];
            sat_calc = 1'b1;
        end else if (shifted < OUT_MIN) begin
            res_calc = OUT_MIN[W_OUT-1:0];
            sat_calc = 1'b1;
        end
    end

    always_comb begin
        v1_d      = v1_q;
        op1_d     = op1_q;
        id1_d     = id1_q;
        v2_d      = v2_q;
        res2_d    = res2_q;
        id2_d     = id2_q;
        sat2_d    = sat2_q;
        ptr_d     = ptr_q;
        sat_cnt_d = sat_cnt_q;

        if (adv2) begin
            v2_d = v1_q;
            if (v1_q) begin
                res2_d = res_calc;
                id2_d  = id1_q;
                sat2_d = sat_calc;
            end
        end

        if (adv1) begin
            v1_d = transfer;
        end
        if (transfer) begin
            op1_d = rq.req_data[int'(grant_idx)*W_IN +: W_IN];
            id1_d = grant_idx;
            ptr_d = (int'(grant_idx) == N_REQ - 1) ? '0 : grant_idx + IDW'(1);
        end

        // Clear wins over a same-cycle increment; the count sticks at all-ones.
        if (sat_clear) begin
            sat_cnt_d = '0;
        end else if (v2_q && rq.out_ready && sat2_q && (sat_cnt_q != 16'hFFFF)) begin
            sat_cnt_d = sat_cnt_q + 16'd1;
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            v1_q      <= 1'b0;
            op1_q     <= '0;
            id1_q     <= '0;
            v2_q      <= 1'b0;
            res2_q    <= '0;
            id2_q     <= '0;
            sat2_q    <= 1'b0;
            ptr_q     <= '0;
            sat_cnt_q <= '0;
        end else begin
            v1_q      <= v1_d;
            op1_q     <= op1_d;
            id1_q     <= id1_d;
            v2_q      <= v2_d;
            res2_q    <= res2_d;
            id2_q     <= id2_d;
            sat2_q    <= sat2_d;
            ptr_q     <= ptr_d;
            sat_cnt_q <= sat_cnt_d;
        end
    end

    assign rq.out_valid = v2_q;
    assign rq.out_data  = res2_q;
    assign rq.out_id    = id2_q;
    assign rq.out_sat   = sat2_q;
    assign sat_count    = sat_cnt_q;
endmodule

// File: tb/tb_q_requant_arbiter.sv
// Scoreboard bench for q_requant_arbiter: directed vectors push hand-computed results,
// an independent monitor pops and compares on every output handshake.
module tb_q_requant_arbiter;
    localparam int N_REQ = 4;
    localparam int W_IN  = 24;

    typedef struct packed {
        logic [15:0] data;
        logic [1:0]  id;
        logic        sat;
    } exp_t;

    logic        clock;
    logic        reset_n;
    logic        sat_clear;
    logic [15:0] sat_count;

    int   total = 0;
    int   bad   = 0;
    int   cyc   = 0;
    exp_t exp_q[$];
    int   pop_cycles[$];

    logic [23:0] fair_data [4];
    logic [15:0] fair_exp  [4];

    q_requant_arbiter_if #(.N_REQ(4), .IN_I(8), .IN_F(16), .OUT_F(8)) bus ();

    q_requant_arbiter #(.N_REQ(4), .IN_I(8), .IN_F(16), .OUT_F(8)) dut (
        .clock    (clock),
        .reset_n  (reset_n),
        .rq       (bus),
        .sat_clear(sat_clear),
        .sat_count(sat_count)
    );

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    initial begin
        forever begin
            @(posedge clock);
            cyc++;
        end
    end

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: got=timeout want=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        total++;
        if (actual !== expected) begin
            bad++;
            $display("[TB] FAIL %s: got=0x%0h want=0x%0h (t=%0t)", name, actual, expected, $time);
        end
    endtask

    task automatic pushExp(input logic [15:0] d, input logic [1:0] id, input logic s);
        exp_t e;
        e.data = d;
        e.id   = id;
        e.sat  = s;
        exp_q.push_back(e);
    endtask

    // Monitor: every output handshake must match the oldest expectation.
    initial begin
        exp_t e;
        forever begin
            @(negedge clock);
            if (reset_n && bus.out_valid && bus.out_ready) begin
                if (exp_q.size() == 0) begin
                    checkOutput("unexpected_out", 32'(bus.out_data), 32'hDEAD_BEEF);
                end else begin
                    e = exp_q.pop_front();
                    checkOutput("out_data", 32'(bus.out_data), 32'(e.data));
                    checkOutput("out_id",   32'(bus.out_id),   32'(e.id));
                    checkOutput("out_sat",  32'(bus.out_sat),  32'(e.sat));
                    pop_cycles.push_back(cyc);
                end
            end
        end
    end

    task automatic applyStimulus(input int id, input logic [23:0] data);
        bit done = 0;
        bus.req_data[id*W_IN +: W_IN] = data;
        bus.req_valid[id] = 1'b1;
        for (int i = 0; i < 50 && !done; i++) begin
            @(negedge clock);
            if (bus.req_ready[id]) begin
                @(posedge clock);
                #1;
                done = 1;
            end
        end
        bus.req_valid[id] = 1'b0;
        checkOutput("accept", 32'(done), 32'd1);
    endtask

    task automatic runAccepts(input int target, input int maxCycles, output int got, output int used);
        int n;
        got  = 0;
        used = 0;
        while (got < target && used < maxCycles) begin
            @(negedge clock);
            n = $countones(bus.req_valid & bus.req_ready);
            @(posedge clock);
            #1;
            got += n;
            used++;
        end
    endtask

    task automatic waitDrain();
        int i = 0;
        while ((exp_q.size() != 0 || bus.out_valid) && i < 100) begin
            @(posedge clock);
            #1;
            i++;
        end
        checkOutput("drain_left", 32'(exp_q.size()), 32'd0);
    endtask

    initial begin
        int got, used, stale;
        fair_data[0] = 24'h000100; fair_exp[0] = 16'h0001;
        fair_data[1] = 24'h000280; fair_exp[1] = 16'h0003;
        fair_data[2] = 24'hFFFF00; fair_exp[2] = 16'hFFFF;
        fair_data[3] = 24'h123456; fair_exp[3] = 16'h1234;

        reset_n       = 1'b0;
        sat_clear     = 1'b0;
        bus.req_valid = 4'hF;
        bus.req_data  = '0;
        bus.out_ready = 1'b1;
        repeat (3) @(posedge clock);
        #1;
        checkOutput("rst_out_valid", 32'(bus.out_valid), 32'd0);
        checkOutput("rst_req_ready", 32'(bus.req_ready), 32'd0);
        checkOutput("rst_sat_count", 32'(sat_count), 32'd0);
        checkOutput("rst_out_data",  32'(bus.out_data), 32'd0);
        bus.req_valid = 4'h0;
        reset_n = 1'b1;
        @(posedge clock);
        #1;

        $display("[TB] rounding and latency");
        pushExp(16'h0002, 2'd0, 1'b0);
        applyStimulus(0, 24'h000180);
        checkOutput("lat_edge_k", 32'(bus.out_valid), 32'd0);
        @(posedge clock);
        #1;
        checkOutput("lat_edge_k1", 32'(bus.out_valid), 32'd1);
        pushExp(16'hFFFF, 2'd1, 1'b0);
        applyStimulus(1, 24'hFFFE80);
        pushExp(16'h8000, 2'd2, 1'b0);
        applyStimulus(2, 24'h800000);
        waitDrain();

        $display("[TB] saturation counter");
        for (int k = 0; k < 3; k++) begin
            pushExp(16'h7FFF, 2'd3, 1'b1);
            applyStimulus(3, 24'h7FFFFF);
        end
        waitDrain();
        checkOutput("sat_count_3", 32'(sat_count), 32'd3);
        bus.out_ready = 1'b0;
        pushExp(16'h7FFF, 2'd3, 1'b1);
        applyStimulus(3, 24'h7FFFFF);
        for (int i = 0; i < 10 && !bus.out_valid; i++) begin
            @(posedge clock);
            #1;
        end
        checkOutput("sat4_presented", 32'(bus.out_valid), 32'd1);
        checkOutput("sat4_count_held", 32'(sat_count), 32'd3);
        sat_clear     = 1'b1;
        bus.out_ready = 1'b1;
        @(posedge clock);
        #1;
        sat_clear = 1'b0;
        checkOutput("sat_clear_wins", 32'(sat_count), 32'd0);
        waitDrain();

        $display("[TB] fairness");
        for (int i = 0; i < N_REQ; i++) bus.req_data[i*W_IN +: W_IN] = fair_data[i];
        for (int r = 0; r < 2; r++)
            for (int i = 0; i < N_REQ; i++) pushExp(fair_exp[i], 2'(i), 1'b0);
        bus.req_valid = 4'hF;
        runAccepts(8, 20, got, used);
        bus.req_valid = 4'h0;
        checkOutput("fair_accepts", 32'(got), 32'd8);
        checkOutput("fair_cycles", 32'(used), 32'd8);
        waitDrain();
        if (pop_cycles.size() >= 8)
            checkOutput("fair_back_to_back",
                        32'(pop_cycles[pop_cycles.size()-1] - pop_cycles[pop_cycles.size()-8]), 32'd7);
        else
            checkOutput("fair_pop_count", 32'(pop_cycles.size()), 32'd8);

        $display("[TB] backpressure");
        pushExp(fair_exp[0], 2'd0, 1'b0);
        pushExp(fair_exp[1], 2'd1, 1'b0);
        pushExp(fair_exp[2], 2'd2, 1'b0);
        pushExp(fair_exp[3], 2'd3, 1'b0);
        pushExp(fair_exp[0], 2'd0, 1'b0);
        pushExp(fair_exp[1], 2'd1, 1'b0);
        bus.out_ready = 1'b0;
        bus.req_valid = 4'hF;
        runAccepts(100, 5, got, used);
        checkOutput("bp_accepts", 32'(got), 32'd2);
        checkOutput("bp_req_ready", 32'(bus.req_ready), 32'd0);
        checkOutput("bp_out_valid", 32'(bus.out_valid), 32'd1);
        checkOutput("bp_out_data", 32'(bus.out_data), 32'(fair_exp[0]));
        checkOutput("bp_out_id", 32'(bus.out_id), 32'd0);
        bus.out_ready = 1'b1;
        runAccepts(4, 20, got, used);
        bus.req_valid = 4'h0;
        checkOutput("bp_release_accepts", 32'(got), 32'd4);
        waitDrain();

        $display("[TB] async reset with both stages full");
        bus.out_ready = 1'b0;
        bus.req_valid = 4'b0110;
        runAccepts(100, 3, got, used);
        checkOutput("pre_rst_accepts", 32'(got), 32'd2);
        checkOutput("pre_rst_valid", 32'(bus.out_valid), 32'd1);
        checkOutput("pre_rst_id", 32'(bus.out_id), 32'd2);
        #3;
        reset_n = 1'b0;
        #1;
        checkOutput("async_out_valid", 32'(bus.out_valid), 32'd0);
        checkOutput("async_req_ready", 32'(bus.req_ready), 32'd0);
        checkOutput("async_out_data", 32'(bus.out_data), 32'd0);
        bus.req_valid = 4'h0;
        repeat (2) @(posedge clock);
        #1;
        reset_n = 1'b1;
        bus.out_ready = 1'b1;
        stale = 0;
        for (int i = 0; i < 3; i++) begin
            @(posedge clock);
            #1;
            if (bus.out_valid) stale++;
        end
        checkOutput("no_stale_result", 32'(stale), 32'd0);
        pushExp(fair_exp[0], 2'd0, 1'b0);
        pushExp(fair_exp[1], 2'd1, 1'b0);
        bus.req_valid = 4'hF;
        runAccepts(2, 10, got, used);
        bus.req_valid = 4'h0;
        checkOutput("post_rst_accepts", 32'(got), 32'd2);
        waitDrain();
        checkOutput("final_sat_count", 32'(sat_count), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/q_requant_arbiter.md
Name: q_requant_arbiter

Overview:
- Shares one rounding/saturating fixed-point requantizer (Q(IN_I,IN_F) -> Q(IN_I,OUT_F)) among N_REQ requesters, e.g. the score, row-max and accumulator lanes of the attention datapath.
- Round-robin arbitration, valid/ready on every port, 2-stage pipeline.
- Results are tagged with the requester id.
- Keeps a saturation event counter for numeric-health monitoring.

Parameters:
- N_REQ, 4, number of requesters (2..16).
- IN_I, 8, integer bits including sign.
- IN_F, 16, input fractional bits.
- OUT_F, 8, output fractional bits; must be < IN_F.
- Derived: W_IN = IN_I+IN_F, W_OUT = IN_I+OUT_F, SH = IN_F-OUT_F, IDW = max(1, clog2(N_REQ)).

Ports:
- clock  in  1  rising-edge clock.
- reset_n  in  1  asynchronous active-low reset.
- req_valid  in  N_REQ  per-requester valid.
- req_data  in  N_REQ*W_IN  packed signed operands; requester i occupies bits [i*W_IN +: W_IN].
- req_ready  out  N_REQ  per-requester ready, one-hot or zero.
- out_valid  out  1  result valid.
- out_ready  in  1  consumer ready.
- out_data  out  W_OUT  requantized signed result.
- out_id  out  IDW  index of the requester that produced the result.
- out_sat  out  1  result was clamped.
- sat_count  out  16  saturation events since reset/clear.
- sat_clear  in  1  synchronous clear of sat_count.

Behaviour:
- Reset (async, reset_n=0) clears:
  - S1 and S2 valid bits; out_valid=0, out_sat=0.
  - Data, id and out_data registers to 0.
  - Round-robin pointer to 0 and sat_count to 0.
  - Any in-flight items are discarded. req_ready=0 while in reset.
- Pipeline stages:
  - S1 holds {v1, operand, id}; S2 holds {v2, result, id, sat}.
  - adv2 = !v2 | out_ready; adv1 = !v1 | adv2.
  - S2 loads from S1 when adv2: v2 <= v1.
  - S1 loads the granted request when adv1: v1 <= (any grant).
- Arbitration (combinational):
  - Search req_valid starting at ptr, ascending with wrap. The first asserted index g is granted.
  - req_ready[g] = adv1; all other req_ready bits are 0. When adv1=0, all req_ready are 0.
  - A transfer occurs when req_valid[g] & req_ready[g]. On transfer, ptr <= (g+1) mod N_REQ; otherwise ptr holds.
  - A requester must hold valid and data stable until accepted. The arbiter never drops a granted request.
- Latency and throughput:
  - A request accepted at edge k is presented at out_valid after edge k+1, i.e. 2 edges.
  - Throughput is 1 result/cycle while out_ready=1.
  - out_* stays stable while out_valid=1 and out_ready=0.
- Arithmetic, computed between S1 and S2:
  - e = sign-extend operand to W_IN+1 bits.
  - s = e + 2^(SH-1); r = s >>> SH (arithmetic). This is round-half-up.
  - Clamp r to [-2^(W_OUT-1), 2^(W_OUT-1)-1]; out_sat = 1 iff clamping occurred.
  - Nothing wraps: the extra bit prevents overflow of the bias add.
- Saturation counter:
  - sat_count increments by 1 on each output handshake (out_valid & out_ready) with out_sat=1.
  - It sticks at 0xFFFF.
  - sat_clear has priority: if it coincides with an increment, the count becomes 0.
- Simultaneous events:
  - Output consumption and new acceptance in the same cycle are both honoured (full throughput).
  - With S2 full and out_ready=0 and S1 full, no grants are issued.
  - With S2 full and out_ready=0 and S1 empty, one request is still accepted into S1.
- Reset asserted mid-transfer: outputs drop immediately (async). After deassertion, arbitration restarts at requester 0.

Test Plan:
- Single requester 0, req_data=0x000180 (+1.5 LSB) -> out_data=0x0002, out_id=0, out_sat=0, out_valid exactly 2 edges after accept.
- Negative half-way and minimum: 0xFFFE80 -> 0xFFFF (-1, round half up); 0x800000 -> 0x8000 with out_sat=0.
- Saturation: 0x7FFFFF -> 0x7FFF, out_sat=1. After 3 such handshakes sat_count=3. Pulsing sat_clear in the same cycle as a 4th saturating handshake -> sat_count=0.
- Fairness: all 4 requesters hold valid continuously, out_ready=1 -> out_id sequence 0,1,2,3,0,1…, one result per cycle, no requester starved.
- Backpressure: out_ready=0 for 5 cycles with all requesters valid -> exactly 2 items accepted (S1 and S2 fill), req_ready all 0 afterwards, out_data stable. Releasing out_ready -> results appear in grant order with none lost or duplicated.
- Async reset asserted with both stages full -> out_valid=0 immediately. After release, the next grant goes to requester 0 and no stale result appears.
